mul_div_unit: RTL

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mdu_pkg.sv | 63 ++++++
 rtl/mdu_iter_core.sv | 35 +++
 rtl/mul_div_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, FSM states, decode helpers.
package mdu_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_MUL    = 4'h0;
    localparam logic [OP_W-1:0] OP_MULH   = 4'h1;
    localparam logic [OP_W-1:0] OP_MULHSU = 4'h2;
    localparam logic [OP_W-1:0] OP_MULHU  = 4'h3;
    localparam logic [OP_W-1:0] OP_DIV    = 4'h4;
    localparam logic [OP_W-1:0] OP_DIVU   = 4'h5;
    localparam logic [OP_W-1:0] OP_REM    = 4'h6;
    localparam logic [OP_W-1:0] OP_REMU   = 4'h7;
    localparam logic [OP_W-1:0] OP_MULW   = 4'h8;
    localparam logic [OP_W-1:0] OP_DIVW   = 4'hC;
    localparam logic [OP_W-1:0] OP_DIVUW  = 4'hD;
    localparam logic [OP_W-1:0] OP_REMW   = 4'hE;
    localparam logic [OP_W-1:0] OP_REMUW  = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    // Unknown codes, and word ops on a build without them, execute as MUL.
    function automatic logic [OP_W-1:0] legal_op(input logic [OP_W-1:0] op, input logic word_en);
        logic ok;
        case (op)
            4'h9, 4'hA, 4'hB: ok = 1'b0;
            default:          ok = !op[3] || word_en;
        endcase
        return ok ? op : OP_MUL;
    endfunction

    // The helpers below expect an op already passed through legal_op.
    function automatic logic is_word(input logic [OP_W-1:0] op);
        return op[3];
    endfunction

    function automatic logic is_div(input logic [OP_W-1:0] op);
        return op[2];
    endfunction

    function automatic logic is_rem(input logic [OP_W-1:0] op);
        return op[2] && op[1];
    endfunction

    function automatic logic is_mulh(input logic [OP_W-1:0] op);
        return !op[2] && !op[3] && (op[1:0] != 2'b00);
    endfunction

    // rs1 treated as signed
    function automatic logic is_signed(input logic [OP_W-1:0] op);
        return op[2] ? !op[0] : (!op[3] && (op[1:0] == 2'b01 || op[1:0] == 2'b10));
    endfunction

    // rs2 treated as signed
    function automatic logic is_signed_b(input logic [OP_W-1:0] op);
        return op[2] ? !op[0] : (!op[3] && op[1:0] == 2'b01);
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// One radix-2 step on unsigned magnitudes: shift-add multiply or restoring divide,
// sharing a single XLEN+1 bit adder.
module mdu_iter_core #(
    parameter int unsigned XLEN = 64
) (
    input  logic            div_mode,
    input  logic [XLEN:0]   hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] opb,
    output logic [XLEN:0]   hi_next,
    output logic [XLEN-1:0] lo_next
);

    logic [XLEN:0] x;
    logic [XLEN:0] y;
    logic [XLEN:0] sum;
    logic [XLEN:0] acc;
    logic          qbit;

    always_comb begin
        x       = div_mode ? {hi[XLEN-1:0], lo[XLEN-1]} : hi;
        y       = div_mode ? ~{1'b0, opb} : {1'b0, opb};
        sum     = x + y + (XLEN+1)'(div_mode);
        // Partial remainder stays below the divisor, so the top bit is a clean borrow.
        qbit    = ~sum[XLEN];
        acc     = lo[0] ? sum : hi;
        hi_next = {1'b0, acc[XLEN:1]};
        lo_next = {acc[0], lo[XLEN-1:1]};
        if (div_mode) begin
            hi_next = qbit ? sum : x;
            lo_next = {lo[XLEN-2:0], qbit};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RISC-V M-extension multiply/divide unit with valid/ready handshakes
// and flush; one result bit per cycle.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned W_OPS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result
);

    localparam int unsigned CNT_W   = $clog2(XLEN + 1);
    localparam int unsigned WSH     = XLEN - 32;
    localparam logic        WORD_EN = (W_OPS != 0) && (XLEN == 64);

    state_t              state_q, state_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [XLEN:0]       hi_q, hi_d, hi_nxt;
    logic [XLEN-1:0]     lo_q, lo_d, lo_nxt;
    logic [XLEN-1:0]     opb_q, opb_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, n_iter;
    logic                spec_q, spec_d;
    logic                neg_q, neg_d;
    logic                in_ready_d, out_valid_d;
    logic [XLEN-1:0]     out_result_d;

    logic [OP_W-1:0]     op_l;
    logic                word, sa, sb, neg_a, neg_b, b_zero, a_min, ovf, spec;
    logic [XLEN-1:0]     opa_x, opb_x, mag_a, mag_b, div_a, spec_res;
    logic [2*XLEN-1:0]   pre, fix;
    logic [31:0]         w_val;
    logic [XLEN-1:0]     res;

    // Request decode: sign handling, magnitudes and the no-iteration special cases.
    always_comb begin
        op_l   = legal_op(in_op, WORD_EN);
        word   = is_word(op_l);
        sa     = is_signed(op_l);
        sb     = is_signed_b(op_l);
        opa_x  = word ? (sa ? XLEN'($signed(in_a[31:0])) : XLEN'(in_a[31:0])) : in_a;
        opb_x  = word ? (sb ? XLEN'($signed(in_b[31:0])) : XLEN'(in_b[31:0])) : in_b;
        neg_a  = sa && opa_x[XLEN-1];
        neg_b  = sb && opb_x[XLEN-1];
        mag_a  = neg_a ? -opa_x : opa_x;
        mag_b  = neg_b ? -opb_x : opb_x;
        div_a  = word ? XLEN'($signed(in_a[31:0])) : in_a;
        b_zero = (opb_x == '0);
        a_min  = word ? (in_a[31:0] == 32'h8000_0000) : (in_a == {1'b1, {(XLEN-1){1'b0}}});
        ovf    = sa && sb && a_min && (&opb_x);
        spec   = is_div(op_l) && (b_zero || ovf);
        if (b_zero) spec_res = is_rem(op_l) ? div_a : '1;
        else        spec_res = is_rem(op_l) ? '0 : div_a;
    end

    mdu_iter_core #(.XLEN(XLEN)) u_core (
        .div_mode (is_div(op_q)),
        .hi       (hi_q),
        .lo       (lo_q),
        .opb      (opb_q),
        .hi_next  (hi_nxt),
        .lo_next  (lo_nxt)
    );

    // Result fix-up: restore sign, pick the half or word, sign-extend word results.
    always_comb begin
        n_iter = is_word(op_q) ? CNT_W'(32) : CNT_W'(XLEN);
        if (is_div(op_q)) pre = {{XLEN{1'b0}}, is_rem(op_q) ? hi_q[XLEN-1:0] : lo_q};
        else              pre = {hi_q[XLEN-1:0], lo_q};
        fix   = neg_q ? -pre : pre;
        w_val = is_div(op_q) ? fix[31:0] : fix[XLEN-1:XLEN-32];
        if (spec_q)             res = lo_q;
        else if (is_word(op_q)) res = XLEN'($signed(w_val));
        else if (is_mulh(op_q)) res = fix[2*XLEN-1:XLEN];
        else                    res = fix[XLEN-1:0];
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        opb_d        = opb_q;
        cnt_d        = cnt_q;
        spec_d       = spec_q;
        neg_d        = neg_q;
        out_result_d = out_result;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_BUSY;
                    op_d    = op_l;
                    hi_d    = '0;
                    opb_d   = mag_b;
                    cnt_d   = '0;
                    spec_d  = spec;
                    neg_d   = is_rem(op_l) ? neg_a : (neg_a ^ neg_b);
                    if (spec)                       lo_d = spec_res;
                    else if (is_div(op_l) && word)  lo_d = mag_a << WSH;
                    else                            lo_d = mag_a;
                end
            end
            S_BUSY: begin
                if (spec_q || cnt_q == n_iter) begin
                    out_result_d = res;
                    state_d      = S_DONE;
                end else begin
                    hi_d  = hi_nxt;
                    lo_d  = lo_nxt;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= OP_MUL;
            hi_q       <= '0;
            lo_q       <= '0;
            opb_q      <= '0;
            cnt_q      <= '0;
            spec_q     <= 1'b0;
            neg_q      <= 1'b0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_result <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            opb_q      <= opb_d;
            cnt_q      <= cnt_d;
            spec_q     <= spec_d;
            neg_q      <= neg_d;
            in_ready   <= in_ready_d;
            out_valid  <= out_valid_d;
            out_result <= out_result_d;
        end
    end

endmodule
